ecc_core_arbiter: RTL and testbench



---
 rtl/ecc_core_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ecc_core_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_core_arbiter.sv
// ecc_core_arbiter
// Shares one ECC scalar-multiplication core (start/finish pulse interface)
// between two requesters. A job is accepted by valid/ready, its operands are
// latched and held on core_* for the whole job, core_start pulses once, and on
// core_finish the result is captured and returned to the owning requester by
// valid/ready.
//
// Build option:
//   ECC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, requester 0 wins a tie
//                          undefined -> round robin between the two requesters
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   req_valid/req_ready [1:0]     per-requester job handshake (ready only in IDLE)
//   req_a/p/x/y/n [2*WIDTH-1:0]   per-requester operands, slice i = [i*WIDTH +: WIDTH]
//   req_mode [3:0]                per-requester mode, slice i = [2i +: 2]
//   rsp_valid/rsp_ready [1:0]     per-requester result handshake
//   rsp_x, rsp_y                  result point, meaningful while rsp_valid != 0
//   core_start                    one-cycle registered start pulse
//   core_a/p/x/y/n, core_mode     latched operands, stable for the whole job
//   core_finish, core_result_x/y  completion pulse and result from the core
//   busy                          high outside IDLE
//   owner                         requester holding the core (last grant in IDLE)
//
// States:
//   IDLE  | waiting for a job, arbitration active
//   START | core_start high for this single cycle
//   BUSY  | core running, operands held, waiting for core_finish
//   RESP  | result presented to the owner, waiting for rsp_ready

module ecc_core_arbiter #(
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_p,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [2*WIDTH-1:0] req_y,
  input  logic [2*WIDTH-1:0] req_n,
  input  logic [3:0]         req_mode,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_x,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               core_start,
  output logic [WIDTH-1:0]   core_a,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_x,
  output logic [WIDTH-1:0]   core_y,
  output logic [WIDTH-1:0]   core_n,
  output logic [1:0]         core_mode,
  input  logic               core_finish,
  input  logic [WIDTH-1:0]   core_result_x,
  input  logic [WIDTH-1:0]   core_result_y,
  output logic               busy,
  output logic               owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             core_start_q, core_start_d;
  logic [WIDTH-1:0] core_a_q, core_a_d;
  logic [WIDTH-1:0] core_p_q, core_p_d;
  logic [WIDTH-1:0] core_x_q, core_x_d;
  logic [WIDTH-1:0] core_y_q, core_y_d;
  logic [WIDTH-1:0] core_n_q, core_n_d;
  logic [1:0]       core_mode_q, core_mode_d;
  logic [WIDTH-1:0] rsp_x_q, rsp_x_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             winner;
  logic             grant;
`ifndef ECC_ARB_FIXED_PRIO_EN
  logic             rr_last_q, rr_last_d;
`endif

  function automatic logic [WIDTH-1:0] pick(input logic [2*WIDTH-1:0] v, input logic sel);
    return sel ? v[2*WIDTH-1:WIDTH] : v[WIDTH-1:0];
  endfunction

  // Arbitration. With no valid requester the winner is a don't-care because
  // grant is qualified by req_valid[winner].
  always_comb begin : arb
`ifdef ECC_ARB_FIXED_PRIO_EN
    winner = ~req_valid[0];
`else
    winner = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
`endif
    // rst gating keeps req_ready low while reset is held, like every other output.
    grant = (state_q == IDLE) && req_valid[winner] && !rst;
    req_ready = 2'b00;
    req_ready[winner] = grant;
  end

  always_comb begin : fsm
    state_d      = state_q;
    owner_d      = owner_q;
    core_start_d = 1'b0;
    core_a_d     = core_a_q;
    core_p_d     = core_p_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    core_n_d     = core_n_q;
    core_mode_d  = core_mode_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
`ifndef ECC_ARB_FIXED_PRIO_EN
    rr_last_d    = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = START;
          owner_d      = winner;
          core_start_d = 1'b1;
          core_a_d     = pick(req_a, winner);
          core_p_d     = pick(req_p, winner);
          core_x_d     = pick(req_x, winner);
          core_y_d     = pick(req_y, winner);
          core_n_d     = pick(req_n, winner);
          core_mode_d  = winner ? req_mode[3:2] : req_mode[1:0];
`ifndef ECC_ARB_FIXED_PRIO_EN
          rr_last_d    = winner;
`endif
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        // A finish seen in START belongs to no job of ours and is dropped there.
        if (core_finish) begin
          rsp_x_d = core_result_x;
          rsp_y_d = core_result_y;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_p_q     <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_n_q     <= '0;
      core_mode_q  <= 2'b00;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
`ifndef ECC_ARB_FIXED_PRIO_EN
      rr_last_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      core_start_q <= core_start_d;
      core_a_q     <= core_a_d;
      core_p_q     <= core_p_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_n_q     <= core_n_d;
      core_mode_q  <= core_mode_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
`ifndef ECC_ARB_FIXED_PRIO_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  always_comb begin : rsp_out
    rsp_valid = 2'b00;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;
  assign core_start = core_start_q;
  assign core_a     = core_a_q;
  assign core_p     = core_p_q;
  assign core_x     = core_x_q;
  assign core_y     = core_y_q;
  assign core_n     = core_n_q;
  assign core_mode  = core_mode_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_y      = rsp_y_q;

endmodule

// File: tb/tb_ecc_core_arbiter.sv
module tb_ecc_core_arbiter;
  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready;
  logic [2*W-1:0] req_a, req_p, req_x, req_y, req_n;
  logic [3:0]     req_mode;
  logic [1:0]     rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_x, rsp_y;
  logic           core_start;
  logic [W-1:0]   core_a, core_p, core_x, core_y, core_n;
  logic [1:0]     core_mode;
  logic           core_finish;
  logic [W-1:0]   core_result_x, core_result_y;
  logic           busy, owner;

  always #5 clk = ~clk;

  ecc_core_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_p(req_p), .req_x(req_x), .req_y(req_y), .req_n(req_n),
    .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .core_start(core_start),
    .core_a(core_a), .core_p(core_p), .core_x(core_x), .core_y(core_y), .core_n(core_n),
    .core_mode(core_mode),
    .core_finish(core_finish), .core_result_x(core_result_x), .core_result_y(core_result_y),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic [W-1:0] a, p, x, y, n;
    logic [1:0]   mode;
    logic [W-1:0] ex, ey;
  } job_t;

  typedef struct {
    logic         own;
    logic [W-1:0] a, p, x, y, n;
    logic [1:0]   mode;
  } start_t;

  typedef struct {
    logic [1:0]   v;
    logic [W-1:0] x, y;
  } rsp_t;

  job_t   jobs[8];
  start_t exp_start[$];
  rsp_t   exp_rsp[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  logic   force_finish = 1'b0;
  int     core_lat = 4;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic job_t mk(input logic [W-1:0] a, p, x, y, n, input logic [1:0] mode,
                              input logic [W-1:0] ex, ey);
    job_t j;
    j.a = a; j.p = p; j.x = x; j.y = y; j.n = n; j.mode = mode; j.ex = ex; j.ey = ey;
    return j;
  endfunction

  // Stub core plus scoreboard monitors, all sampled on the falling edge.
  // The stub returns (6,3) for 2*(5,1) on the p=17, a=2 curve and (x+n, y+a)
  // for every other job, so each operand's path into the core is observable.
  initial begin : core_and_monitors
    int           cnt;
    logic [W-1:0] rx, ry;
    logic         fin, fin_prev, rsp_seen;
    start_t       es;
    rsp_t         er;
    cnt = 0; rx = '0; ry = '0; fin = 1'b0; fin_prev = 1'b0; rsp_seen = 1'b0;
    core_finish = 1'b0; core_result_x = '0; core_result_y = '0;
    forever begin
      @(negedge clk);
      if (fin_prev) check("rsp_valid_after_finish", W'(rsp_valid != 2'b00), W'(1'b1));
      if (core_start) begin
        check("core_start_expected", W'(exp_start.size() != 0), W'(1'b1));
        if (exp_start.size() != 0) begin
          es = exp_start.pop_front();
          check("start_owner", W'(owner), W'(es.own));
          check("core_a", core_a, es.a);
          check("core_p", core_p, es.p);
          check("core_x", core_x, es.x);
          check("core_y", core_y, es.y);
          check("core_n", core_n, es.n);
          check("core_mode", W'(core_mode), W'(es.mode));
        end
      end
      if (rsp_valid != 2'b00) begin
        if (!rsp_seen) begin
          check("rsp_expected", W'(exp_rsp.size() != 0), W'(1'b1));
          if (exp_rsp.size() != 0) begin
            er = exp_rsp.pop_front();
            check("rsp_valid", W'(rsp_valid), W'(er.v));
            check("rsp_x", rsp_x, er.x);
            check("rsp_y", rsp_y, er.y);
          end
          rsp_seen = 1'b1;
        end
      end else begin
        rsp_seen = 1'b0;
      end
      fin = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (core_start) begin
        cnt = core_lat;
        if (core_p == W'(17) && core_a == W'(2) && core_x == W'(5) && core_y == W'(1) && core_n == W'(2)) begin
          rx = W'(6); ry = W'(3);
        end else begin
          rx = core_x + core_n; ry = core_y + core_a;
        end
      end else if (cnt > 0) begin
        cnt--;
        fin = (cnt == 0);
      end
      core_finish   = fin | force_finish;
      core_result_x = fin ? rx : (force_finish ? {W{1'b1}} : '0);
      core_result_y = fin ? ry : (force_finish ? {W{1'b1}} : '0);
      fin_prev = fin;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input int r, input job_t j);
    if (r == 0) begin
      req_a[W-1:0] = j.a; req_p[W-1:0] = j.p; req_x[W-1:0] = j.x;
      req_y[W-1:0] = j.y; req_n[W-1:0] = j.n; req_mode[1:0] = j.mode;
    end else begin
      req_a[2*W-1:W] = j.a; req_p[2*W-1:W] = j.p; req_x[2*W-1:W] = j.x;
      req_y[2*W-1:W] = j.y; req_n[2*W-1:W] = j.n; req_mode[3:2] = j.mode;
    end
    req_valid[r] = 1'b1;
  endtask

  task automatic push(input int r, input job_t j);
    start_t s;
    rsp_t   e;
    s.own = r[0]; s.a = j.a; s.p = j.p; s.x = j.x; s.y = j.y; s.n = j.n; s.mode = j.mode;
    e.v = (r == 1) ? 2'b10 : 2'b01; e.x = j.ex; e.y = j.ey;
    exp_start.push_back(s);
    exp_rsp.push_back(e);
  endtask

  // Presents a job, waits (bounded) for its ready, and leaves the bench one
  // step after the accepting edge, i.e. inside the START cycle.
  task automatic issue(input int r, input job_t j);
    int n;
    n = 0;
    present(r, j);
    #1;
    while (!req_ready[r] && n < 300) begin
      step();
      n++;
    end
    check("req_ready_granted", W'(req_ready[r]), W'(1'b1));
    push(r, j);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    check("core_start_after_accept", W'(core_start), W'(1'b1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check("return_to_idle", W'(busy), W'(1'b0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         n;
    int         exp_w[4];
    int         l0[4];
    int         l1[4];
    int         idx[2];
    int         w;
    logic [1:0] e;

    jobs[0] = mk(2, 17, 5, 1, 2, 2'd0, 6, 3);
    jobs[1] = mk(3, 23, 10, 20, 7, 2'd1, 17, 23);
    jobs[2] = mk(4, 29, 100, 200, 9, 2'd2, 109, 204);
    jobs[3] = mk(5, 31, 1000, 50, 11, 2'd3, 1011, 55);
    jobs[4] = mk(6, 37, 7, 8, 33, 2'd1, 40, 14);
    jobs[5] = mk(1, 41, 12, 13, 100, 2'd2, 112, 14);
    jobs[6] = mk(9, 43, 300, 400, 5, 2'd0, 305, 409);
    jobs[7] = mk(128'h8000_0000_0000_0000_0000_0000_0000_0000, {W{1'b1}},
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF0, 128'h1234, 128'h5, 2'd3,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF5,
                 128'h8000_0000_0000_0000_0000_0000_0000_1234);

    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0; req_p = '0; req_x = '0; req_y = '0; req_n = '0; req_mode = 4'h0;
    rsp_ready = 2'b11;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", W'(busy), W'(1'b0));
    check("reset_core_start", W'(core_start), W'(1'b0));
    check("reset_rsp_valid", W'(rsp_valid), W'(2'b00));
    check("reset_req_ready", W'(req_ready), W'(2'b00));
    check("reset_owner", W'(owner), W'(1'b0));
    check("reset_core_a", core_a, '0);
    check("reset_rsp_x", rsp_x, '0);
    rst = 1'b0;
    step();

    // Spurious finish while IDLE
    force_finish = 1'b1;
    step();
    force_finish = 1'b0;
    step();
    check("idle_finish_busy", W'(busy), W'(1'b0));
    check("idle_finish_rsp_valid", W'(rsp_valid), W'(2'b00));
    check("idle_finish_core_start", W'(core_start), W'(1'b0));

    // Single job on requester 0 with a spurious finish during START
    core_lat = 4;
    issue(0, jobs[0]);
    force_finish = 1'b1;
    @(negedge clk);
    #1;
    force_finish = 1'b0;
    step();
    check("start_finish_busy", W'(busy), W'(1'b1));
    check("start_finish_rsp_valid", W'(rsp_valid), W'(2'b00));
    wait_idle();
    check("owner_after_job0", W'(owner), W'(1'b0));

    // Operand stability while the requester changes its inputs
    core_lat = 8;
    issue(1, jobs[1]);
    req_a = {2*W{1'b1}};
    req_p = {2*W{1'b1}};
    req_n = {2*W{1'b1}};
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      step();
      n++;
      check("hold_core_a", core_a, jobs[1].a);
      check("hold_core_p", core_p, jobs[1].p);
      check("hold_core_n", core_n, jobs[1].n);
    end
    wait_idle();

    // Response backpressure; only the non-owner ready bit is set
    core_lat = 3;
    rsp_ready = 2'b10;
    issue(0, jobs[2]);
    n = 0;
    while (rsp_valid == 2'b00 && n < 50) begin
      step();
      n++;
    end
    check("bp_rsp_seen", W'(rsp_valid != 2'b00), W'(1'b1));
    present(1, jobs[3]);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_rsp_valid", W'(rsp_valid), W'(2'b01));
      check("bp_rsp_x", rsp_x, jobs[2].ex);
      check("bp_rsp_y", rsp_y, jobs[2].ey);
      check("bp_req_ready", W'(req_ready), W'(2'b00));
      check("bp_core_start", W'(core_start), W'(1'b0));
    end
    rsp_ready = 2'b11;
    step();
    check("req_ready_after_rsp", W'(req_ready), W'(2'b10));
    issue(1, jobs[3]);
    wait_idle();

    // Reset in the middle of BUSY
    core_lat = 10;
    issue(1, jobs[4]);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_busy", W'(busy), W'(1'b0));
    check("midrst_core_start", W'(core_start), W'(1'b0));
    check("midrst_rsp_valid", W'(rsp_valid), W'(2'b00));
    check("midrst_req_ready", W'(req_ready), W'(2'b00));
    check("midrst_owner", W'(owner), W'(1'b0));
    check("midrst_core_a", core_a, '0);
    check("midrst_core_p", core_p, '0);
    check("midrst_core_x", core_x, '0);
    check("midrst_core_y", core_y, '0);
    check("midrst_core_n", core_n, '0);
    check("midrst_core_mode", W'(core_mode), W'(2'b00));
    check("midrst_rsp_x", rsp_x, '0);
    check("midrst_rsp_y", rsp_y, '0);
    exp_rsp.delete();
    step();
    step();
    rst = 1'b0;

    // Both requesters valid from reset, back to back
`ifdef ECC_ARB_FIXED_PRIO_EN
    exp_w = '{0, 0, 0, 0};
`else
    exp_w = '{0, 1, 0, 1};
`endif
    l0 = '{5, 6, 7, 1};
    l1 = '{2, 3, 4, 0};
    idx = '{0, 0};
    core_lat = 2;
    present(0, jobs[l0[0]]);
    present(1, jobs[l1[0]]);
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 300) begin
        step();
        n++;
      end
      w = exp_w[k];
      e = (w == 1) ? 2'b10 : 2'b01;
      check("grant_order", W'(req_ready), W'(e));
      push(w, (w == 1) ? jobs[l1[idx[1]]] : jobs[l0[idx[0]]]);
      @(posedge clk);
      #1;
      idx[w] = idx[w] + 1;
      if (k < 3) begin
        if (w == 1) present(1, jobs[l1[idx[1]]]);
        else        present(0, jobs[l0[idx[0]]]);
      end else begin
        req_valid = 2'b00;
      end
    end
    wait_idle();

    repeat (3) step();
    check("start_queue_drained", W'(exp_start.size()), W'(0));
    check("rsp_queue_drained", W'(exp_rsp.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
